// File: rtl/rv32_barrel_fetch.sv
// rv32_barrel_fetch: per-hart PCs sharing one I-mem read port in strict round-robin slots.
// Define PITO_FETCH_PERF_EN to add saturating per-hart fetch counters on perf_fetch_cnt.
module rv32_barrel_fetch #(
    parameter int              NUM_HARTS     = 8,
    parameter int              HART_W        = $clog2(NUM_HARTS),
    parameter int              XLEN          = 32,
    parameter int              IMEM_AW       = 12,
    parameter logic [XLEN-1:0] RESET_ADDRESS = '0
) (
    input  logic                 rv32_io_clk,
    input  logic                 rv32_io_rst_n,
    input  logic                 rv32_io_program,
    input  logic [NUM_HARTS-1:0] hart_stall,
    input  logic                 redirect_valid,
    input  logic [HART_W-1:0]    redirect_hart,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [IMEM_AW-1:0]   imem_raddr,
    input  logic [31:0]          imem_rdata,
    output logic                 fetch_valid,
    output logic [HART_W-1:0]    fetch_hart,
    output logic [XLEN-1:0]      fetch_pc,
    output logic [31:0]          fetch_instr
`ifdef PITO_FETCH_PERF_EN
    ,
    output logic [NUM_HARTS*32-1:0] perf_fetch_cnt
`endif
);

    logic [XLEN-1:0]   r_pc [NUM_HARTS];
    logic [HART_W-1:0] r_ptr;
    logic              r_f1_valid;
    logic [HART_W-1:0] r_f1_hart;
    logic [XLEN-1:0]   r_f1_pc;

    logic [XLEN-1:0]   w_cur_pc;
    logic              w_redir_slot;
    logic              w_issue;
    logic [XLEN-1:0]   w_redir_pc;

    assign w_cur_pc     = r_pc[r_ptr];
    assign w_redir_slot = redirect_valid && (redirect_hart == r_ptr);
    assign w_issue      = !rv32_io_program && !hart_stall[r_ptr] && !w_redir_slot;
    assign w_redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_raddr   = w_cur_pc[IMEM_AW+1:2];

    // Redirect wins over the increment; a redirected slot never issues anyway.
    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_pc[h] <= RESET_ADDRESS;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (redirect_valid && (redirect_hart == HART_W'(h))) begin
                    r_pc[h] <= w_redir_pc;
                end else if (w_issue && (r_ptr == HART_W'(h))) begin
                    r_pc[h] <= r_pc[h] + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            r_ptr      <= '0;
            r_f1_valid <= 1'b0;
            r_f1_hart  <= '0;
            r_f1_pc    <= '0;
        end else begin
            if (!rv32_io_program) begin
                r_ptr <= r_ptr + HART_W'(1);
            end
            r_f1_valid <= w_issue;
            r_f1_hart  <= r_ptr;
            r_f1_pc    <= w_cur_pc;
        end
    end

    // Late redirect for the hart already in F1 squashes its word on the way out.
    assign fetch_valid = r_f1_valid & ~(redirect_valid & (redirect_hart == r_f1_hart));
    assign fetch_hart  = r_f1_hart;
    assign fetch_pc    = r_f1_pc;
    assign fetch_instr = imem_rdata;

`ifdef PITO_FETCH_PERF_EN
    logic [31:0] r_perf_cnt [NUM_HARTS];

    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_perf_cnt[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (fetch_valid && (fetch_hart == HART_W'(h)) && (r_perf_cnt[h] != 32'hFFFF_FFFF)) begin
                    r_perf_cnt[h] <= r_perf_cnt[h] + 32'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_perf_out
        assign perf_fetch_cnt[gi*32 +: 32] = r_perf_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_rv32_barrel_fetch.sv
// Directed bench for rv32_barrel_fetch with NUM_HARTS=4; covers PITO_FETCH_PERF_EN when defined.
module tb_rv32_barrel_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog = 1'b0;
    logic [3:0]  hart_stall = '0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_hart = '0;
    logic [31:0] redirect_pc = '0;
    logic [11:0] imem_raddr;
    logic [31:0] imem_rdata = '0;
    logic        fetch_valid;
    logic [1:0]  fetch_hart;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
`ifdef PITO_FETCH_PERF_EN
    logic [127:0] perf_fetch_cnt;
`endif

    int tests = 0;
    int fails = 0;

    rv32_barrel_fetch #(.NUM_HARTS(4), .XLEN(32), .IMEM_AW(12), .RESET_ADDRESS(32'h0)) dut (
        .rv32_io_clk     (clk),
        .rv32_io_rst_n   (rst_n),
        .rv32_io_program (prog),
        .hart_stall      (hart_stall),
        .redirect_valid  (redirect_valid),
        .redirect_hart   (redirect_hart),
        .redirect_pc     (redirect_pc),
        .imem_raddr      (imem_raddr),
        .imem_rdata      (imem_rdata),
        .fetch_valid     (fetch_valid),
        .fetch_hart      (fetch_hart),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr)
`ifdef PITO_FETCH_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous I-mem model: each word encodes its own word address.
    always @(posedge clk) imem_rdata <= 32'hA000_0000 | {20'h0, imem_raddr};

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA000_0000 | {20'h0, pc[13:2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({fetch_valid, fetch_hart, fetch_pc, imem_raddr} !== 47'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%0b h=%0d pc=%h raddr=%h, want all 0",
                     fetch_valid, fetch_hart, fetch_pc, imem_raddr);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({fetch_valid, imem_raddr} !== 13'h0) begin
            fails++;
            $display("FAIL rr_first_cycle: got v=%0b raddr=%h, want v=0 raddr=000", fetch_valid, imem_raddr);
        end
        for (int k = 0; k < 12; k++) begin
            logic [31:0] epc;
            epc = 32'(4 * (k / 4));
            tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc, fetch_instr} !== {1'b1, 2'(k % 4), epc, instr_of(epc)}) begin
                fails++;
                $display("FAIL rr[%0d]: got v=%0b h=%0d pc=%h instr=%h, want v=1 h=%0d pc=%h instr=%h",
                         k, fetch_valid, fetch_hart, fetch_pc, fetch_instr, k % 4, epc, instr_of(epc));
            end
            tests++;
            if (imem_raddr !== 12'((k + 1) / 4)) begin
                fails++;
                $display("FAIL rr_raddr[%0d]: got %h, want %h", k, imem_raddr, 12'((k + 1) / 4));
            end
            $display("[TB] rr fetch hart=%0d pc=%h", fetch_hart, fetch_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rpc [4];
        hart_stall = 4'b0010;
        for (int j = 0; j < 8; j++) begin
            int h;
            logic [31:0] epc;
            h   = j % 4;
            epc = (h == 1) ? 32'd12 : ((j < 4) ? 32'd12 : 32'd16);
            tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {(h != 1), 2'(h), epc}) begin
                fails++;
                $display("FAIL stall[%0d]: got v=%0b h=%0d pc=%h, want v=%0b h=%0d pc=%h",
                         j, fetch_valid, fetch_hart, fetch_pc, (h != 1), h, epc);
            end
        end
        hart_stall = 4'b0000;
        rpc = '{32'd20, 32'd12, 32'd20, 32'd20};
        for (int h = 0; h < 4; h++) begin
            tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 2'(h), rpc[h]}) begin
                fails++;
                $display("FAIL stall_after[%0d]: got v=%0b h=%0d pc=%h, want v=1 h=%0d pc=%h",
                         h, fetch_valid, fetch_hart, fetch_pc, h, rpc[h]);
            end
        end
    endtask

    task automatic test_redirect_slot();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_hart  = 2'd2;
        redirect_pc    = 32'h103;
        #1;
        tests++;
        if ({fetch_valid, imem_raddr} !== {1'b1, 12'h006}) begin
            fails++;
            $display("FAIL redir_pre: got v=%0b raddr=%h, want v=1 raddr=006", fetch_valid, imem_raddr);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        tests++;
        if ({fetch_valid, fetch_hart} !== {1'b0, 2'd2}) begin
            fails++;
            $display("FAIL redir_cancel: got v=%0b h=%0d, want v=0 h=2", fetch_valid, fetch_hart);
        end
        repeat (3) tick();
        tests++;
        if (imem_raddr !== 12'h040) begin
            fails++;
            $display("FAIL redir_raddr: got %h, want 040", imem_raddr);
        end
        tick();
        tests++;
        if ({fetch_valid, fetch_hart, fetch_pc, fetch_instr} !== {1'b1, 2'd2, 32'h100, instr_of(32'h100)}) begin
            fails++;
            $display("FAIL redir_fetch: got v=%0b h=%0d pc=%h instr=%h, want v=1 h=2 pc=00000100 instr=%h",
                     fetch_valid, fetch_hart, fetch_pc, fetch_instr, instr_of(32'h100));
        end
    endtask

    task automatic test_inflight_kill();
        logic [31:0] epc [4];
        tick();
        redirect_valid = 1'b1;
        redirect_hart  = 2'd3;
        redirect_pc    = 32'h200;
        #1;
        tests++;
        if ({fetch_valid, fetch_hart} !== {1'b0, 2'd3}) begin
            fails++;
            $display("FAIL kill_same: got v=%0b h=%0d, want v=0 h=3", fetch_valid, fetch_hart);
        end
        redirect_hart = 2'd1;
        #1;
        tests++;
        if (fetch_valid !== 1'b1) begin
            fails++;
            $display("FAIL kill_other: got v=%0b, want v=1", fetch_valid);
        end
        redirect_hart = 2'd3;
        tick();
        redirect_valid = 1'b0;
        epc = '{32'd32, 32'd24, 32'h104, 32'h200};
        for (int h = 0; h < 4; h++) begin
            if (h != 0) tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 2'(h), epc[h]}) begin
                fails++;
                $display("FAIL kill_after[%0d]: got v=%0b h=%0d pc=%h, want v=1 h=%0d pc=%h",
                         h, fetch_valid, fetch_hart, fetch_pc, h, epc[h]);
            end
        end
    endtask

    task automatic test_program();
        logic [31:0] epc [4];
        tick();
        prog = 1'b1;
        #1;
        tests++;
        if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 2'd0, 32'd36}) begin
            fails++;
            $display("FAIL prog_enter: got v=%0b h=%0d pc=%h, want v=1 h=0 pc=00000024",
                     fetch_valid, fetch_hart, fetch_pc);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                redirect_valid = 1'b1;
                redirect_hart  = 2'd2;
                redirect_pc    = 32'h300;
            end
            tick();
            redirect_valid = 1'b0;
            #1;
            tests++;
            if ({fetch_valid, imem_raddr} !== {1'b0, 12'h007}) begin
                fails++;
                $display("FAIL prog_hold[%0d]: got v=%0b raddr=%h, want v=0 raddr=007", i, fetch_valid, imem_raddr);
            end
        end
        prog = 1'b0;
        #1;
        tests++;
        if (imem_raddr !== 12'h007) begin
            fails++;
            $display("FAIL prog_resume_raddr: got %h, want 007", imem_raddr);
        end
        epc = '{32'd40, 32'd28, 32'h300, 32'h204};
        for (int k = 0; k < 4; k++) begin
            int h;
            h = (k + 1) % 4;
            tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 2'(h), epc[h]}) begin
                fails++;
                $display("FAIL prog_resume[%0d]: got v=%0b h=%0d pc=%h, want v=1 h=%0d pc=%h",
                         k, fetch_valid, fetch_hart, fetch_pc, h, epc[h]);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({fetch_valid, fetch_hart, fetch_pc, imem_raddr} !== 47'h0) begin
            fails++;
            $display("FAIL reset_mid: got v=%0b h=%0d pc=%h raddr=%h, want all 0",
                     fetch_valid, fetch_hart, fetch_pc, imem_raddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int h = 0; h < 2; h++) begin
            tick();
            tests++;
            if ({fetch_valid, fetch_hart, fetch_pc} !== {1'b1, 2'(h), 32'd0}) begin
                fails++;
                $display("FAIL reset_mid_restart[%0d]: got v=%0b h=%0d pc=%h, want v=1 h=%0d pc=0",
                         h, fetch_valid, fetch_hart, fetch_pc, h);
            end
        end
    endtask

`ifdef PITO_FETCH_PERF_EN
    task automatic test_perf();
        logic [31:0] ecnt [4];
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) tick();
        ecnt = '{32'd25, 32'd25, 32'd25, 32'd24};
        for (int h = 0; h < 4; h++) begin
            tests++;
            if (perf_fetch_cnt[h*32 +: 32] !== ecnt[h]) begin
                fails++;
                $display("FAIL perf_cnt[%0d]: got %0d, want %0d", h, perf_fetch_cnt[h*32 +: 32], ecnt[h]);
            end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (perf_fetch_cnt !== 128'h0) begin
            fails++;
            $display("FAIL perf_reset: got %h, want 0", perf_fetch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_redirect_slot();
        test_inflight_kill();
        test_program();
        test_reset_mid();
`ifdef PITO_FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
